// File: rtl/sram_mem_ctrl.sv
// Splits one 32-bit load/store into two WAIT_CYCLES-long 16-bit async-SRAM accesses (low half, then high half).
// Optional `SRAM_HIT_REG_EN: one-entry last-access register lets repeat reads of the same word skip the SRAM.
module sram_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int         WW   = SRAM_AW - 1;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [WW-1:0] word;
    logic [WW-1:0] req_word;
    logic [31:0]   wdata;
    logic          is_wr;
    logic          req;
    logic          hit;
    logic          start;
    logic          busy;
    logic          phase_end;

    // Offset wraps modulo 2^32; byte-lane bits and anything above the SRAM range are dropped.
    assign req_word  = WW'((address - BASE_ADDR) >> 2);
    assign req       = rd_en | wr_en;
    assign phase_end = (cnt == LAST);
    assign busy      = (state == LOW) || (state == HIGH);

`ifdef SRAM_HIT_REG_EN
    logic          hit_vld;
    logic [WW-1:0] hit_word;
    logic [31:0]   hit_data;

    assign hit = hit_vld && (hit_word == req_word) && rd_en && !wr_en;
`else
    assign hit = 1'b0;
`endif

    assign start = (state == IDLE) && req && !hit;
    assign ready = (state == DONE) || ((state == IDLE) && (!req || hit));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe releases on the last cycle of each phase so address/data are held past we_n rising.
    always_comb begin
        sram_addr   = {word, (state == HIGH)};
        sram_dq_oe  = is_wr && busy;
        sram_we_n   = !(is_wr && busy && !phase_end);
        sram_dq_out = 16'h0000;
        if (is_wr && (state == LOW))
            sram_dq_out = wdata[15:0];
        else if (is_wr && (state == HIGH))
            sram_dq_out = wdata[31:16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word      <= '0;
            wdata     <= 32'd0;
            is_wr     <= 1'b0;
            read_data <= 32'd0;
        end else begin
            if (start) begin
                word  <= req_word;
                wdata <= write_data;
                is_wr <= wr_en;
            end
            if (!is_wr && phase_end && (state == LOW))
                read_data[15:0] <= sram_dq_in;
            if (!is_wr && phase_end && (state == HIGH))
                read_data[31:16] <= sram_dq_in;
`ifdef SRAM_HIT_REG_EN
            if ((state == IDLE) && hit)
                read_data <= hit_data;
`endif
        end
    end

`ifdef SRAM_HIT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_vld  <= 1'b0;
            hit_word <= '0;
            hit_data <= 32'd0;
        end else if ((state == HIGH) && phase_end) begin
            hit_vld  <= 1'b1;
            hit_word <= word;
            hit_data <= is_wr ? wdata : {sram_dq_in, read_data[15:0]};
        end
    end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: async-SRAM model, word-level reference memory, directed and random accesses.
module tb_sram_mem_ctrl;

    localparam int          W    = 2;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk = 1'b0;
    logic          rst, rd_en, wr_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    // External SRAM device
    logic [15:0] sram [0:(1<<AW)-1];
    always @(posedge clk) if (sram_dq_oe && !sram_we_n) sram[sram_addr] <= sram_dq_out;
    assign sram_dq_in = sram[sram_addr];

    // Reference: 32-bit words by word index, last completed read, last-access entry
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] ref_rd = 32'd0;
    bit          hit_vld = 1'b0;
    int unsigned hit_w = 0;
    logic [31:0] hit_d = 32'd0;

    int            exp_busy;
    logic [31:0]   exp_rd;
    logic          req_ready;
    int            obs_n;
    logic [AW-1:0] obs_addr [64];
    logic [15:0]   obs_dq   [64];
    logic          obs_we_n [64];
    logic          obs_oe   [64];

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 32'((off / 4) % (32'd1 << (AW - 1)));
    endfunction

    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        int unsigned w;
        bit          is_hit;
        w      = widx(a);
        is_hit = 1'b0;
`ifdef SRAM_HIT_REG_EN
        is_hit = rd && !wr && hit_vld && (hit_w == w);
`endif
        if (wr) begin
            ref_mem[w] = d;
            exp_busy   = 2 * W;
            hit_d      = d;
        end else begin
            ref_rd   = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
            exp_busy = is_hit ? 0 : 2 * W;
            hit_d    = ref_rd;
        end
        hit_vld = 1'b1;
        hit_w   = w;
        exp_rd  = ref_rd;

        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        #1 req_ready = ready;
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        obs_n = 0;
        forever begin
            @(negedge clk);
            if (ready || obs_n == 64) break;
            obs_addr[obs_n] = sram_addr;
            obs_dq[obs_n]   = sram_dq_out;
            obs_we_n[obs_n] = sram_we_n;
            obs_oe[obs_n]   = sram_dq_oe;
            obs_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total += 5;
        if (ready !== 1'b1)      begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (sram_we_n !== 1'b1)  begin bad++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
        if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
        if (read_data !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
        if (sram_addr !== '0)    begin bad++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
    endtask

    task automatic test_write();
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        run_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        total += 2;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL write_req_ready got=%b exp=0", req_ready); end
        if (obs_n != exp_busy)  begin bad++; $display("FAIL write_busy got=%0d exp=%0d", obs_n, exp_busy); end
        for (int i = 0; i < obs_n && i < 2 * W; i++) begin
            ea = (i < W) ? AW'(4) : AW'(5);
            ed = (i < W) ? 16'hBEEF : 16'hDEAD;
            total++;
            if (obs_addr[i] !== ea || obs_dq[i] !== ed || obs_oe[i] !== 1'b1 ||
                obs_we_n[i] !== ((i % W) == W - 1)) begin
                bad++;
                $display("FAIL write_phase cyc=%0d got addr=%h dq=%h oe=%b we_n=%b exp addr=%h dq=%h",
                         i, obs_addr[i], obs_dq[i], obs_oe[i], obs_we_n[i], ea, ed);
            end
        end
    endtask

    task automatic test_read_back();
        run_op(1'b1, 1'b0, 32'd1032, 32'd0);
        total += 3;
        if (obs_n != exp_busy)   begin bad++; $display("FAIL readback_busy got=%0d exp=%0d", obs_n, exp_busy); end
        if (read_data !== exp_rd) begin bad++; $display("FAIL readback_data got=%h exp=%h", read_data, exp_rd); end
        if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL readback_const got=%h exp=deadbeef", read_data); end
    endtask

    task automatic test_wrap();
        run_op(1'b0, 1'b1, 32'd1023, 32'h12345678);
        total += 3;
        if (obs_n != 2 * W) begin bad++; $display("FAIL wrap_busy got=%0d exp=%0d", obs_n, 2 * W); end
        if (obs_addr[0] !== 18'h3FFFE) begin bad++; $display("FAIL wrap_lo_addr got=%h exp=3fffe", obs_addr[0]); end
        if (obs_addr[W] !== 18'h3FFFF) begin bad++; $display("FAIL wrap_hi_addr got=%h exp=3ffff", obs_addr[W]); end
        run_op(1'b1, 1'b0, 32'd1021, 32'd0);
        total += 2;
        if (obs_n != exp_busy) begin bad++; $display("FAIL wrap_rd_busy got=%0d exp=%0d", obs_n, exp_busy); end
        if (read_data !== 32'h12345678) begin bad++; $display("FAIL wrap_rd_data got=%h exp=12345678", read_data); end
    endtask

    task automatic test_simultaneous();
        int pulses;
        run_op(1'b1, 1'b1, 32'd1024, 32'h0000A5A5);
        pulses = 0;
        for (int i = 0; i < obs_n; i++) if (obs_we_n[i] === 1'b0) pulses++;
        total += 3;
        if (obs_n != exp_busy)    begin bad++; $display("FAIL both_busy got=%0d exp=%0d", obs_n, exp_busy); end
        if (pulses != 2 * (W - 1)) begin bad++; $display("FAIL both_we_pulses got=%0d exp=%0d", pulses, 2 * (W - 1)); end
        if (read_data !== exp_rd) begin bad++; $display("FAIL both_rdata got=%h exp=%h", read_data, exp_rd); end
        if (sram[0] !== 16'hA5A5 || sram[1] !== 16'h0000) begin
            bad++; $display("FAIL both_sram got=%h_%h exp=0000_a5a5", sram[1], sram[0]);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (W + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 5;
        if (ready !== 1'b1)      begin bad++; $display("FAIL abort_ready got=%b exp=1", ready); end
        if (sram_we_n !== 1'b1)  begin bad++; $display("FAIL abort_we_n got=%b exp=1", sram_we_n); end
        if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b exp=0", sram_dq_oe); end
        if (read_data !== 32'd0) begin bad++; $display("FAIL abort_rdata got=%h exp=0", read_data); end
        if (sram_addr !== '0)    begin bad++; $display("FAIL abort_addr got=%h exp=0", sram_addr); end
        rst = 1'b0;
        ref_mem.delete(widx(32'd1040));
        ref_rd  = 32'd0;
        hit_vld = 1'b0;
        run_op(1'b1, 1'b0, 32'd1032, 32'd0);
        total += 2;
        if (obs_n != 2 * W) begin bad++; $display("FAIL after_abort_busy got=%0d exp=%0d", obs_n, 2 * W); end
        if (read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL after_abort_data got=%h exp=deadbeef", read_data); end
        run_op(1'b1, 1'b0, 32'd1034, 32'd0);
        total += 3;
        if (obs_n != exp_busy) begin bad++; $display("FAIL repeat_busy got=%0d exp=%0d", obs_n, exp_busy); end
        if (req_ready !== (exp_busy == 0)) begin bad++; $display("FAIL repeat_req_ready got=%b exp=%b", req_ready, exp_busy == 0); end
        if (read_data !== exp_rd) begin bad++; $display("FAIL repeat_data got=%h exp=%h", read_data, exp_rd); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        bit          rd, wr;
        for (int k = 0; k < 8; k++) run_op(1'b0, 1'b1, BASE + 32'(4 * k), $urandom);
        for (int n = 0; n < 60; n++) begin
            a  = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            rd = ($urandom_range(0, 2) != 0);
            wr = !rd || ($urandom_range(0, 4) == 0);
            run_op(rd, wr, a, d);
            total += 2;
            if (obs_n != exp_busy) begin bad++; $display("FAIL rand_busy n=%0d got=%0d exp=%0d", n, obs_n, exp_busy); end
            if (read_data !== exp_rd) begin bad++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, read_data, exp_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
